// File: rtl/pipe_sel_reg_pkg.sv
// Shared constants for the P6 stage-boundary select registers.
// Combinational helpers only; no state, no flow control.
package pipe_sel_reg_pkg;

  localparam int PIPE_DW       = 32;
  localparam int PIPE_STALL_CW = 16;

  // Forwarding source indices used on the D/E and E/M select inputs
  localparam int FWD_RF  = 0;
  localparam int FWD_EM  = 1;
  localparam int FWD_MW  = 2;
  localparam int FWD_PC8 = 3;

  typedef enum logic [1:0] {
    UPD_NORMAL = 2'd0,
    UPD_STALL  = 2'd1,
    UPD_FLUSH  = 2'd2
  } upd_t;

  // Flush outranks stall; reset is handled separately and outranks both.
  function automatic upd_t upd_decode(input logic stall, input logic flush);
    if (flush)
      return UPD_FLUSH;
    else if (stall)
      return UPD_STALL;
    else
      return UPD_NORMAL;
  endfunction

endpackage

// File: rtl/nsrc_mux.sv
// N:1 combinational select, zero when sel is out of range.
// Latency 0; no flow control.
module nsrc_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2
) (
  input  logic [NSRC*WIDTH-1:0] din,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      dout
);

  always_comb begin
    dout = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k))
        dout = din[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pipe_sel_reg.sv
// N:1 select into a pipeline register with stall/flush/valid, 1-cycle latency.
// Stall holds all state, flush inserts a bubble; optional stall_cnt via PIPE_SEL_STALL_CNT_EN.
module pipe_sel_reg
  import pipe_sel_reg_pkg::*;
#(
  parameter int WIDTH        = PIPE_DW,
  parameter int NSRC         = 4,
  parameter int SELW         = 2,
  parameter bit HOLD_INVALID = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSRC*WIDTH-1:0]    din,
  input  logic [SELW-1:0]          sel,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     out_valid,
`ifdef PIPE_SEL_STALL_CNT_EN
  output logic [PIPE_STALL_CW-1:0] stall_cnt,
`endif
  output logic                     sel_err
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_oor;
  upd_t             upd;

  nsrc_mux #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) u_mux (
    .din  (din),
    .sel  (sel),
    .dout (sel_data)
  );

  assign sel_oor = ({1'b0, sel} >= (SELW+1)'(NSRC));
  assign upd     = upd_decode(stall, flush);

  always_ff @(posedge clk) begin
    if (reset) begin
      dout      <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      case (upd)
        UPD_FLUSH: begin
          dout      <= '0;
          out_valid <= 1'b0;
        end
        UPD_NORMAL: begin
          out_valid <= in_valid;
          if (in_valid) begin
            dout <= sel_data;
            if (sel_oor)
              sel_err <= 1'b1;
          end else if (!HOLD_INVALID) begin
            dout <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_SEL_STALL_CNT_EN
  // Saturating: a stuck stall must read as "at least 65535", never wrap to small.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (upd == UPD_STALL && stall_cnt != {PIPE_STALL_CW{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule
